uart_instr_loader: RTL
======================

// Module: uart_instr_loader
// PURPOSE
//  Collects the byte stream from the UART receiver and pairs bytes into 16-bit instruction words.
//  Writes each word into the instruction memory at consecutive addresses.
//  Declares the program loaded after a line-idle timeout; the start-CPU logic waits on o_transmit_done.
//  Sits between the UART RX and the instruction RAM write port, ahead of the CPU sequencer.
// PARAMETERS
//  ADDR_W        8       instruction memory address width
//  START_ADDR    1       address written by the first instruction of a program
//  IDLE_TIMEOUT  200000  idle clocks after the last byte before the load is declared complete (>=2)
// PORTS
//  i_clk            in   1       system clock
//  i_rst            in   1       asynchronous reset, active-high
//  i_rx_valid       in   1       one-cycle strobe: i_rx_data holds a received byte
//  i_rx_data        in   8       received byte
//  i_load_en        in   1       1 = loading allowed (held high while the CPU is not started)
//  o_mem_we         out  1       instruction RAM write strobe, one cycle
//  o_mem_addr       out  ADDR_W  write address
//  o_mem_wdata      out  16      instruction word {first byte, second byte}
//  o_transmit_done  out  1       level: program loaded, CPU may start
//  o_max_addr       out  ADDR_W  address of the last instruction written
//  o_busy           out  1       a program load is in progress
//  o_frame_err      out  1       sticky: an odd trailing byte was discarded
//  o_overflow       out  1       sticky: a word arrived after the last address; the word was dropped
// BEHAVIOUR
//  Reset values: every output is 0; the address pointer is set to START_ADDR; the FSM is set to S_IDLE.
//  Reset mid-load aborts the load immediately; no memory write is issued.
//  FSM states: S_IDLE, S_WAIT_LO, S_WRITE, S_GAP, S_DONE.
//   S_IDLE    valid&load_en: latch the byte as the high byte; ptr=START_ADDR; clear the sticky flags; busy=1; go S_WAIT_LO.
//   S_WAIT_LO valid: latch the byte as the low byte; go S_WRITE.
//             idle counter hits IDLE_TIMEOUT: set frame_err and drop the byte.
//             Then go S_DONE if at least one word is written, otherwise go S_IDLE.
//   S_WRITE   mem_we=1, addr=ptr, wdata={hi,lo} for exactly one cycle; max_addr<=ptr; ptr<=ptr+1; go S_GAP.
//             If ptr wrapped past 2^ADDR_W-1 before this word, drive no write, set overflow, and go S_GAP.
//   S_GAP     valid: latch the high byte; go S_WAIT_LO.
//             Idle counter hits IDLE_TIMEOUT: go S_DONE.
//   S_DONE    transmit_done=1, busy=0.
//             valid&load_en: start a new program (same action as S_IDLE); transmit_done drops in the next cycle.
//  Latency: low byte strobe in cycle N -> mem_we high in cycle N+1; max_addr valid in cycle N+2.
//  Idle counter: cleared on every accepted byte; increments every cycle in S_WAIT_LO and S_GAP; saturates.
//  Simultaneous valid and timeout in the same cycle: the byte wins and the counter clears.
//  load_en low: bytes are ignored.
//   Falling edge of load_en in S_WAIT_LO or S_GAP acts as an immediate timeout (same exits as above).
//   S_WRITE always completes.
//  Bytes arrive at UART rate, far slower than the clock; a valid strobe during S_WRITE cannot occur and is ignored.
//  The pointer wraps to detect overflow: after address 2^ADDR_W-1 is written, overflow_pending=1.
// CONFIGURATION
//  Macro INSTR_LOADER_HALT_DETECT_EN.
//   Defined: when a word with wdata[15:13]==3'b111 (HALT) is written, go straight from S_WRITE to S_DONE.
//   transmit_done is asserted one cycle after the write, with no timeout wait. Later bytes start a new program.
//   Undefined: HALT words are not inspected; completion is by timeout only.
// TESTING
//  1 Send 0x41,0x26,0x81,0x80 with valid strobes 100 clk apart, then idle.
//    -> Writes [1]=0x4126 and [2]=0x8180; max_addr=2.
//    -> done rises exactly IDLE_TIMEOUT clk after the last strobe.
//  2 Send 0x41,0x26,0x81, then idle.
//    -> One write, [1]=0x4126; frame_err=1; done=1; max_addr=1.
//  3 Load a program so done=1, then send 0x41,0x00.
//    -> done falls next cycle; write [1]=0x4100; frame_err and overflow cleared; done rises again after timeout.
//  4 ADDR_W=2, START_ADDR=1: send 4 words.
//    -> Writes to addresses 1,2,3; 4th word dropped; overflow=1; max_addr=3.
//  5 Assert i_rst between the high and low byte.
//    -> No mem_we; all outputs 0.
//    -> Next pair is written at START_ADDR.
//  6 With INSTR_LOADER_HALT_DETECT_EN defined, send 0x41,0x00,0xE0,0x00.
//    -> done=1 one cycle after the 0xE000 write to [2]; max_addr=2.
//    Without the macro: done only after timeout.

Source files
------------

// File: rtl/uart_instr_loader.sv
// rtl/uart_instr_loader.sv - pairs UART RX bytes into 16-bit words and writes them to instruction RAM.
// Optional INSTR_LOADER_HALT_DETECT_EN: a written HALT word (wdata[15:13]==3'b111) completes the load at once.
module uart_instr_loader #(
  parameter int ADDR_W       = 8,
  parameter int START_ADDR   = 1,
  parameter int IDLE_TIMEOUT = 200000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  input  logic              i_load_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  output logic              o_transmit_done,
  output logic [ADDR_W-1:0] o_max_addr,
  output logic              o_busy,
  output logic              o_frame_err,
  output logic              o_overflow
);

  localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_HIT = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(IDLE_TIMEOUT);
  localparam logic [ADDR_W-1:0] START   = ADDR_W'(START_ADDR);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_LO, S_WRITE, S_GAP, S_DONE} state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_ptr;
  logic               r_ovf_pend;
  logic               r_any_written;
  logic               r_load_en_d;
  logic [7:0]         r_hi;
  logic [CNT_W-1:0]   r_idle_cnt;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [15:0]        r_mem_wdata;
  logic               r_done;
  logic [ADDR_W-1:0]  r_max_addr;
  logic               r_busy;
  logic               r_frame_err;
  logic               r_overflow;

  logic w_byte;
  logic w_timeout;
  logic w_halt;

  assign w_byte = i_rx_valid & i_load_en;
  // r_idle_cnt is the number of clocks since the last accepted byte; dropping load_en forces an early exit
  assign w_timeout = (r_idle_cnt >= CNT_HIT) | (r_load_en_d & ~i_load_en);

`ifdef INSTR_LOADER_HALT_DETECT_EN
  assign w_halt = (r_mem_wdata[15:13] == 3'b111);
`else
  assign w_halt = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_ptr         <= START;
      r_ovf_pend    <= 1'b0;
      r_any_written <= 1'b0;
      r_load_en_d   <= 1'b0;
      r_hi          <= '0;
      r_idle_cnt    <= '0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_done        <= 1'b0;
      r_max_addr    <= '0;
      r_busy        <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_load_en_d <= i_load_en;
      r_mem_we    <= 1'b0;
      if (r_idle_cnt != CNT_SAT)
        r_idle_cnt <= r_idle_cnt + CNT_W'(1);

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_byte) begin
            r_hi          <= i_rx_data;
            r_ptr         <= START;
            r_ovf_pend    <= 1'b0;
            r_any_written <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overflow    <= 1'b0;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_idle_cnt    <= CNT_W'(1);
            r_state       <= S_WAIT_LO;
          end
        end

        S_WAIT_LO: begin
          if (w_byte) begin
            // Write strobe is issued on entry to S_WRITE so it appears the cycle after the low byte
            if (!r_ovf_pend) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_ptr;
              r_mem_wdata <= {r_hi, i_rx_data};
            end
            r_idle_cnt <= CNT_W'(1);
            r_state    <= S_WRITE;
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_busy      <= 1'b0;
            if (r_any_written) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        S_WRITE: begin
          if (r_ovf_pend) begin
            r_overflow <= 1'b1;
            r_state    <= S_GAP;
          end else begin
            r_max_addr    <= r_ptr;
            r_ptr         <= r_ptr + ADDR_W'(1);
            r_any_written <= 1'b1;
            if (r_ptr == {ADDR_W{1'b1}})
              r_ovf_pend <= 1'b1;
            if (w_halt) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_state <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (w_byte) begin
            r_hi       <= i_rx_data;
            r_idle_cnt <= CNT_W'(1);
            r_state    <= S_WAIT_LO;
          end else if (w_timeout) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_we        = r_mem_we;
  assign o_mem_addr      = r_mem_addr;
  assign o_mem_wdata     = r_mem_wdata;
  assign o_transmit_done = r_done;
  assign o_max_addr      = r_max_addr;
  assign o_busy          = r_busy;
  assign o_frame_err     = r_frame_err;
  assign o_overflow      = r_overflow;

endmodule
